// File: rtl/nes_mirrored_ram_if.sv
// Bus bundle for nes_mirrored_ram: level req / pulsed ack handshake plus decode status.
interface nes_mirrored_ram_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              hit;
  logic              ready;

  modport master (
    output req, write, addr, wdata,
    input  rdata, ack, hit, ready
  );

  modport slave (
    input  req, write, addr, wdata,
    output rdata, ack, hit, ready
  );
endinterface

// File: rtl/nes_mirrored_ram.sv
// Address-decoded, mirrored work RAM with optional wait states and a post-reset clear sweep.
// The window [BASE, BASE+WINDOW) aliases onto DEPTH words; one access is in flight at a time.
module nes_mirrored_ram #(
  parameter int                ADDR_W         = 16,
  parameter int                DATA_W         = 8,
  parameter int                DEPTH          = 2048,
  parameter int unsigned       BASE           = 32'h0000,
  parameter int unsigned       WINDOW         = 32'h2000,
  parameter int                WAIT_STATES    = 0,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input logic               clock,
  input logic               reset,
  nes_mirrored_ram_if.slave bus
);

  localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  BASE_X    = (ADDR_W+1)'(BASE);
  localparam logic [ADDR_W:0]  WINDOW_X  = (ADDR_W+1)'(WINDOW);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [3:0]       WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e            state_q,     state_d;
  logic [3:0]        wait_cnt_q,  wait_cnt_d;
  logic [IDX_W-1:0]  clr_cnt_q,   clr_cnt_d;
  logic              ack_q,       ack_d;
  logic [DATA_W-1:0] rdata_q,     rdata_d;
  logic [IDX_W-1:0]  cap_idx_q,   cap_idx_d;
  logic [DATA_W-1:0] cap_wdata_q, cap_wdata_d;
  logic              cap_write_q, cap_write_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   offset;
  logic [IDX_W-1:0]  bus_idx;
  logic              hit;
  logic              ready;
  logic              accept;

  logic              com_en;
  logic              com_write;
  logic [IDX_W-1:0]  com_idx;
  logic [DATA_W-1:0] com_wdata;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;

  // One extra bit so an address below BASE shows up as a borrow in the MSB.
  assign offset  = {1'b0, bus.addr} - BASE_X;
  assign hit     = !offset[ADDR_W] && (offset < WINDOW_X);
  assign bus_idx = offset[IDX_W-1:0];
  assign ready   = (state_q != ST_CLEAR);
  assign accept  = bus.req && hit && ready && !ack_q && (state_q == ST_IDLE);

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    clr_cnt_d   = clr_cnt_q;
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    cap_idx_d   = cap_idx_q;
    cap_wdata_d = cap_wdata_q;
    cap_write_d = cap_write_q;
    com_en      = 1'b0;
    com_write   = cap_write_q;
    com_idx     = cap_idx_q;
    com_wdata   = cap_wdata_q;
    mem_we      = 1'b0;
    mem_widx    = clr_cnt_q;
    mem_wdata   = CLEAR_VALUE;

    unique case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + IDX_W'(1);
        if (clr_cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          cap_idx_d   = bus_idx;
          cap_wdata_d = bus.wdata;
          cap_write_d = bus.write;
          if (WAIT_STATES == 0) begin
            com_en    = 1'b1;
            com_write = bus.write;
            com_idx   = bus_idx;
            com_wdata = bus.wdata;
          end else begin
            wait_cnt_d = WAIT_LOAD;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // The captured request is used here, so bus changes during WAIT are harmless.
        if (wait_cnt_q <= 4'd1) begin
          com_en     = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (com_en) begin
      ack_d = 1'b1;
      if (com_write) begin
        mem_we    = 1'b1;
        mem_widx  = com_idx;
        mem_wdata = com_wdata;
      end else begin
        rdata_d = mem[com_idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      wait_cnt_q  <= '0;
      clr_cnt_q   <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      cap_idx_q   <= '0;
      cap_wdata_q <= '0;
      cap_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      clr_cnt_q   <= clr_cnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      cap_idx_q   <= cap_idx_d;
      cap_wdata_q <= cap_wdata_d;
      cap_write_q <= cap_write_d;
    end
  end

  // Reset wins over any pending commit, so an interrupted write never lands.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.hit   = hit;
  assign bus.ready = ready;

endmodule

// File: tb/tb_nes_mirrored_ram.sv
// Self-checking bench: three nes_mirrored_ram configurations against a transaction-level model.
module tb_nes_mirrored_ram;

  localparam int NI = 3;

  logic       clock = 1'b0;
  logic       rst     [NI];
  logic       b_req   [NI];
  logic       b_write [NI];
  logic [15:0] b_addr [NI];
  logic [7:0] b_wdata [NI];
  logic       d_ack   [NI];
  logic       d_hit   [NI];
  logic       d_ready [NI];
  logic [7:0] d_rdata [NI];

  int n_checks;
  int n_fail;
  bit checking;

  always #5 clock = ~clock;

  nes_mirrored_ram_if #(.ADDR_W(16), .DATA_W(8)) if_a ();
  nes_mirrored_ram_if #(.ADDR_W(16), .DATA_W(8)) if_b ();
  nes_mirrored_ram_if #(.ADDR_W(16), .DATA_W(8)) if_c ();

  // A: CPU WRAM with clear sweep; B: PRG-RAM window at $6000; C: WRAM with 3 wait states.
  nes_mirrored_ram dut_a (.clock(clock), .reset(rst[0]), .bus(if_a));

  nes_mirrored_ram #(.BASE(32'h6000), .WINDOW(32'h2000), .DEPTH(8192), .CLEAR_ON_RESET(1'b0))
    dut_b (.clock(clock), .reset(rst[1]), .bus(if_b));

  nes_mirrored_ram #(.WAIT_STATES(3), .CLEAR_ON_RESET(1'b0))
    dut_c (.clock(clock), .reset(rst[2]), .bus(if_c));

  assign if_a.req = b_req[0];  assign if_a.write = b_write[0];
  assign if_a.addr = b_addr[0]; assign if_a.wdata = b_wdata[0];
  assign if_b.req = b_req[1];  assign if_b.write = b_write[1];
  assign if_b.addr = b_addr[1]; assign if_b.wdata = b_wdata[1];
  assign if_c.req = b_req[2];  assign if_c.write = b_write[2];
  assign if_c.addr = b_addr[2]; assign if_c.wdata = b_wdata[2];

  assign d_ack[0] = if_a.ack; assign d_hit[0] = if_a.hit;
  assign d_ready[0] = if_a.ready; assign d_rdata[0] = if_a.rdata;
  assign d_ack[1] = if_b.ack; assign d_hit[1] = if_b.hit;
  assign d_ready[1] = if_b.ready; assign d_rdata[1] = if_b.rdata;
  assign d_ack[2] = if_c.ack; assign d_hit[2] = if_c.hit;
  assign d_ready[2] = if_c.ready; assign d_rdata[2] = if_c.rdata;

  function automatic int p_base(int i);
    return (i == 1) ? 32'h6000 : 0;
  endfunction

  function automatic int p_win(int i);
    return (i >= 0) ? 32'h2000 : 0;
  endfunction

  function automatic int p_dep(int i);
    return (i == 1) ? 8192 : 2048;
  endfunction

  function automatic int p_ws(int i);
    return (i == 2) ? 3 : 0;
  endfunction

  function automatic bit p_clr(int i);
    return (i == 0);
  endfunction

  function automatic bit in_window(int i, logic [15:0] a);
    return (int'(a) >= p_base(i)) && ((int'(a) - p_base(i)) < p_win(i));
  endfunction

  // Reference model: memory contents plus "commit due at cycle X" bookkeeping.
  bit         m_clearing [NI];
  int         m_clr_idx  [NI];
  bit         m_pend     [NI];
  longint     m_due      [NI];
  bit         m_pw       [NI];
  int         m_pidx     [NI];
  logic [7:0] m_pd       [NI];
  bit         m_ack      [NI];
  logic [7:0] m_rdata    [NI];
  logic [7:0] mdl_mem    [NI][8192];
  longint     m_cyc;
  bit         m_fired;

  initial begin
    m_cyc = 0;
    forever begin
      @(posedge clock);
      for (int i = 0; i < NI; i++) begin
        if (rst[i]) begin
          m_clearing[i] = p_clr(i);
          m_clr_idx[i]  = 0;
          m_pend[i]     = 1'b0;
          m_ack[i]      = 1'b0;
          m_rdata[i]    = 8'h00;
        end else if (m_clearing[i]) begin
          mdl_mem[i][m_clr_idx[i]] = 8'h00;
          m_clr_idx[i]++;
          if (m_clr_idx[i] == p_dep(i)) m_clearing[i] = 1'b0;
          m_ack[i] = 1'b0;
        end else begin
          m_fired = 1'b0;
          if (!m_pend[i] && !m_ack[i] && b_req[i] && in_window(i, b_addr[i])) begin
            m_pend[i] = 1'b1;
            m_due[i]  = m_cyc + longint'(p_ws(i));
            m_pw[i]   = b_write[i];
            m_pidx[i] = (int'(b_addr[i]) - p_base(i)) % p_dep(i);
            m_pd[i]   = b_wdata[i];
          end
          if (m_pend[i] && (m_due[i] == m_cyc)) begin
            if (m_pw[i]) mdl_mem[i][m_pidx[i]] = m_pd[i];
            else         m_rdata[i] = mdl_mem[i][m_pidx[i]];
            m_pend[i] = 1'b0;
            m_fired   = 1'b1;
          end
          m_ack[i] = m_fired;
        end
      end
      m_cyc++;
    end
  end

  task automatic checkOutput(string nm, int inst, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s inst%0d @%0t: got %0h, expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (checking) begin
        for (int i = 0; i < NI; i++) begin
          checkOutput("ack", i, 32'(d_ack[i]), 32'(m_ack[i]));
          checkOutput("ready", i, 32'(d_ready[i]), 32'(!m_clearing[i]));
          checkOutput("hit", i, 32'(d_hit[i]), 32'(in_window(i, b_addr[i])));
          checkOutput("rdata", i, 32'(d_rdata[i]), 32'(m_rdata[i]));
        end
      end
    end
  end

  task automatic applyStimulus(int i, bit rq, bit wr, logic [15:0] a, logic [7:0] d);
    b_req[i]   = rq;
    b_write[i] = wr;
    b_addr[i]  = a;
    b_wdata[i] = d;
  endtask

  // Counts rising edges until ack is seen on the following falling edge.
  task automatic wait_ack(int i, output int lat);
    lat = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (d_ack[i]) return;
    end
    n_checks++;
    n_fail++;
    $display("[TB] FAIL ack_timeout inst%0d: no ack after %0d cycles, required within 60", i, lat);
    lat = -1;
  endtask

  // Called just after a rising edge; holds req through the ack cycle, then drops it.
  task automatic do_access(int i, bit wr, logic [15:0] a, logic [7:0] d,
                           output int lat, output logic [7:0] rd);
    applyStimulus(i, 1'b1, wr, a, d);
    wait_ack(i, lat);
    rd = d_rdata[i];
    @(posedge clock);
    #1;
    applyStimulus(i, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         lat;
    int         low;
    int         cnt_ack;
    int         cnt_hit;
    logic [7:0] rd;
    logic [15:0] mirrors [3];
    logic [15:0] misses  [2];

    mirrors[0] = 16'h0923; mirrors[1] = 16'h1123; mirrors[2] = 16'h1923;
    misses[0]  = 16'h5FFF; misses[1]  = 16'h8000;
    n_checks = 0;
    n_fail   = 0;
    checking = 1'b0;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1;
      applyStimulus(i, 1'b0, 1'b0, 16'h0000, 8'h00);
    end
    @(posedge clock);
    #1 checking = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;

    $display("[TB] clear sweep with a read of $07FF held from the start");
    applyStimulus(0, 1'b1, 1'b0, 16'h07FF, 8'h00);
    low = 0;
    cnt_ack = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      if (d_ready[0]) break;
      low++;
      if (d_ack[0]) cnt_ack++;
    end
    checkOutput("clear_ready_low_cycles", 0, low, 2048);
    checkOutput("ack_during_clear", 0, cnt_ack, 0);
    wait_ack(0, lat);
    checkOutput("first_ready_accept_latency", 0, lat, 1);
    checkOutput("cleared_07FF", 0, 32'(d_rdata[0]), 32'h00);
    @(posedge clock);
    #1 applyStimulus(0, 1'b0, 1'b0, 16'h0000, 8'h00);

    do_access(0, 1'b0, 16'h0000, 8'h00, lat, rd);
    checkOutput("cleared_0000", 0, 32'(rd), 32'h00);
    do_access(0, 1'b0, 16'h1ABC, 8'h00, lat, rd);
    checkOutput("cleared_1ABC", 0, 32'(rd), 32'h00);

    $display("[TB] zero-wait write and mirrored reads");
    do_access(0, 1'b1, 16'h0123, 8'h5A, lat, rd);
    checkOutput("write_0123_latency", 0, lat, 1);
    checkOutput("write_keeps_rdata", 0, 32'(rd), 32'h00);
    for (int m = 0; m < 3; m++) begin
      do_access(0, 1'b0, mirrors[m], 8'h00, lat, rd);
      checkOutput("mirror_read_latency", 0, lat, 1);
      checkOutput("mirror_read_data", 0, 32'(rd), 32'h5A);
    end

    applyStimulus(0, 1'b1, 1'b0, 16'h2000, 8'h00);
    cnt_ack = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (d_ack[0] || d_hit[0]) cnt_ack++;
    end
    checkOutput("wram_2000_miss", 0, cnt_ack, 0);
    @(posedge clock);
    #1 applyStimulus(0, 1'b0, 1'b0, 16'h0000, 8'h00);

    $display("[TB] PRG-RAM window at $6000");
    for (int m = 0; m < 2; m++) begin
      applyStimulus(1, 1'b1, 1'b1, misses[m], 8'h77);
      cnt_ack = 0;
      cnt_hit = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clock);
        if (d_ack[1]) cnt_ack++;
        if (d_hit[1]) cnt_hit++;
      end
      checkOutput("miss_no_ack", 1, cnt_ack, 0);
      checkOutput("miss_no_hit", 1, cnt_hit, 0);
      @(posedge clock);
      #1 applyStimulus(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    end
    applyStimulus(1, 1'b0, 1'b0, 16'h7FFF, 8'h00);
    @(negedge clock);
    checkOutput("hit_7FFF", 1, 32'(d_hit[1]), 32'h1);
    @(posedge clock);
    #1;
    do_access(1, 1'b1, 16'h6000, 8'hA5, lat, rd);
    checkOutput("prg_write_latency", 1, lat, 1);
    do_access(1, 1'b0, 16'h6000, 8'h00, lat, rd);
    checkOutput("prg_roundtrip", 1, 32'(rd), 32'hA5);

    $display("[TB] three wait states");
    do_access(2, 1'b1, 16'h0010, 8'h3C, lat, rd);
    checkOutput("ws3_write_latency", 2, lat, 4);
    do_access(2, 1'b0, 16'h0010, 8'h00, lat, rd);
    checkOutput("ws3_read_latency", 2, lat, 4);
    checkOutput("ws3_read_data", 2, 32'(rd), 32'h3C);

    applyStimulus(2, 1'b1, 1'b0, 16'h0810, 8'h00);
    wait_ack(2, lat);
    checkOutput("ws3_held_first_latency", 2, lat, 4);
    wait_ack(2, lat);
    checkOutput("ws3_ack_spacing", 2, lat, 5);
    checkOutput("ws3_mirror_data", 2, 32'(d_rdata[2]), 32'h3C);
    @(posedge clock);
    #1 applyStimulus(2, 1'b0, 1'b0, 16'h0000, 8'h00);
    @(posedge clock);
    #1;

    $display("[TB] reset during a wait-state write");
    applyStimulus(2, 1'b1, 1'b1, 16'h0010, 8'hFF);
    @(posedge clock);
    #1 applyStimulus(2, 1'b0, 1'b0, 16'h1234, 8'h00);
    @(posedge clock);
    #1 rst[2] = 1'b1;
    @(posedge clock);
    #1 rst[2] = 1'b0;
    cnt_ack = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (d_ack[2]) cnt_ack++;
    end
    checkOutput("reset_drops_ack", 2, cnt_ack, 0);
    checkOutput("reset_clears_rdata", 2, 32'(d_rdata[2]), 32'h00);
    @(posedge clock);
    #1;
    do_access(2, 1'b0, 16'h0010, 8'h00, lat, rd);
    checkOutput("reset_write_dropped", 2, 32'(rd), 32'h3C);

    repeat (3) @(posedge clock);
    #1 checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nes_mirrored_ram.md
Name: nes_mirrored_ram

Overview:
Parametrised, address-decoded work RAM for the NES CPU/PPU buses. It is the generalised successor to the fixed 2 KB chip-selected RAM, with configurable data width, depth, decode window with mirroring, wait states and a post-reset clear sweep. Each bus master uses it through a level req / pulsed ack handshake. Instances serve CPU WRAM ($0000-$1FFF, 2 KB mirrored ×4), PPU nametable RAM and cartridge PRG-RAM.

Parameters:
ADDR_W, 16, bus address width
DATA_W, 8, data word width
DEPTH, 2048, words of storage; must be a power of two, ≤ WINDOW
BASE, 16'h0000, first decoded address; must be DEPTH-aligned
WINDOW, 16'h2000, decoded span in addresses; power of two, multiple of DEPTH (mirror count = WINDOW/DEPTH)
WAIT_STATES, 0, extra cycles between acceptance and ack (0..15)
CLEAR_ON_RESET, 1, 1 = sweep memory to CLEAR_VALUE after reset
CLEAR_VALUE, 8'h00, fill value for the sweep

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
req  in  1  access request, level; held with addr/wdata/write until ack
write  in  1  1 = write, 0 = read; qualified by req
addr  in  ADDR_W  bus address
wdata  in  DATA_W  write data
rdata  out  DATA_W  read data, valid in the ack cycle, held until the next read
ack  out  1  one-cycle completion pulse
hit  out  1  combinational: addr in [BASE, BASE+WINDOW)
ready  out  1  high when the block can accept requests (not clearing)

Behaviour:
- Decode: hit = (addr >= BASE) && (addr - BASE < WINDOW). Index = (addr - BASE)[log2(DEPTH)-1:0], so mirrors alias. Requests with hit = 0 are ignored: no ack, no state change, no write.
- States: CLEAR, IDLE, WAIT.
- Reset (any cycle, including mid-access): ack=0, rdata=0, wait counter=0, clear counter=0. Next state is CLEAR if CLEAR_ON_RESET=1, else IDLE. A write in progress in WAIT is dropped and memory is unchanged.
- CLEAR: writes CLEAR_VALUE to index k on the k-th cycle (k=0..DEPTH-1), one word per cycle. ready=0 and req is ignored. After the index DEPTH-1 write, the state goes to IDLE and ready=1 from the next cycle. The sweep takes exactly DEPTH cycles. Reset during CLEAR restarts the sweep at 0.
- IDLE acceptance: req & hit & ready & !ack at a rising edge. A cycle with ack=1 never accepts, so a master dropping req on seeing ack is never double-served. The request is captured (addr index, wdata, write) at acceptance.
- WAIT_STATES=0: at the acceptance edge, a write commits mem[idx] <= wdata, or a read loads rdata <= mem[idx]. ack=1 for the following cycle, and the state stays IDLE.
- WAIT_STATES=N>0: the acceptance edge enters WAIT with counter=N. The counter decrements each cycle. On the edge where counter reaches 1, the captured access commits and the state returns to IDLE, with ack=1 for the next cycle. Latency from acceptance edge to ack = N+1 cycles. Inputs may change during WAIT without effect, because the captured values are used.
- Throughput: at most one access per WAIT_STATES+2 cycles.
- Writes never modify rdata. Read-after-write to the same or a mirrored index returns the new data.
- ack is a single-cycle pulse. It never asserts for a non-hit request or while ready=0.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=2048 -> ready=0 for exactly 2048 cycles, then 1. Reading $0000, $07FF and $1ABC all return 8'h00.
- WAIT_STATES=0: write $0123<=8'h5A, then read $0923, $1123 and $1923 -> each ack arrives 1 cycle after acceptance with rdata=8'h5A (mirror aliasing).
- BASE=16'h6000, WINDOW=16'h2000, DEPTH=8192: req to $5FFF and $8000 -> hit=0, no ack within 20 cycles. Write then read $6000 -> 8'hA5 round-trips.
- WAIT_STATES=3: read held with req high -> ack exactly 4 cycles after acceptance; no second acceptance in the ack cycle; next request is accepted one cycle later.
- WAIT_STATES=3: accept write $0010<=8'hFF, assert reset in the 2nd WAIT cycle (CLEAR_ON_RESET=0) -> ack never pulses, and a later read of $0010 returns the prior contents.
- Req asserted while in CLEAR -> no ack until ready=1. The request, held high, is then accepted on the first ready cycle.
